// File: rtl/i2s_tx.sv
// I2S transmitter: serialises 16-bit truncated left/right samples into a
// standard I2S frame of 32 BCK periods, with BCK derived from clk32.
module i2s_tx #(
  parameter int unsigned DIV  = 10,
  parameter int unsigned IN_W = 18
) (
  input  logic                   clk32,
  input  logic                   reset_n,
  input  logic signed [IN_W-1:0] audio_l,
  input  logic signed [IN_W-1:0] audio_r,
  input  logic                   mute,
  output logic                   sample_ack,
  output logic                   I2S_BCK,
  output logic                   I2S_LRCK,
  output logic                   I2S_DATA
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BIT_W  = 5;

  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic              bck_q, bck_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              lrck_q, lrck_d;
  logic              data_q, data_d;
  logic              ack_q, ack_d;
  logic [WORD_W-1:0] left_q, left_d;
  logic [WORD_W-1:0] right_q, right_d;
  logic              fe;
  logic [3:0]        bit_idx;

  // Divider, falling-edge frame sequencing and sample capture
  always_comb begin
    div_cnt_d = div_cnt_q + CNT_W'(1);
    bck_d     = bck_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    data_d    = data_q;
    ack_d     = 1'b0;
    left_d    = left_q;
    right_d   = right_q;
    fe        = 1'b0;
    bit_idx   = 4'd0;

    if (div_cnt_q == CNT_W'(DIV - 1)) begin
      div_cnt_d = '0;
      bck_d     = ~bck_q;
      fe        = bck_q;
    end

    if (fe) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      if (bit_cnt_d == '0) begin
        ack_d = 1'b1;
        if (mute) begin
          left_d  = '0;
          right_d = '0;
        end else begin
          left_d  = audio_l[IN_W-1 -: WORD_W];
          right_d = audio_r[IN_W-1 -: WORD_W];
        end
      end
      // LRCK switches one BCK ahead of each word's MSB
      lrck_d  = (bit_cnt_d >= BIT_W'(15)) && (bit_cnt_d != BIT_W'(31));
      bit_idx = ~bit_cnt_d[3:0];
      data_d  = bit_cnt_d[4] ? right_d[bit_idx] : left_d[bit_idx];
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
      bit_cnt_q <= BIT_W'(31);
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      ack_q     <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  assign sample_ack = ack_q;
  assign I2S_BCK    = bck_q;
  assign I2S_LRCK   = lrck_q;
  assign I2S_DATA   = data_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: expected frames are queued at capture and
// checked by a monitor that deserialises DATA/LRCK on rising BCK.
module tb_i2s_tx;

  localparam int unsigned IN_W = 18;
  localparam logic [31:0] LRCK_EXP = 32'h0001_FFFE;

  logic            clk32 = 1'b0;
  logic            reset_n;
  logic [IN_W-1:0] audio_l, audio_r;
  logic            mute;
  logic            sample_ack, bck, lrck, data;
  logic            ack10, bck10, lrck10, data10;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic mon_en = 1'b1;
  int p10_checks = 0;

  always #5 clk32 = ~clk32;

  i2s_tx #(.DIV(2), .IN_W(IN_W)) dut (
    .clk32(clk32), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
    .mute(mute), .sample_ack(sample_ack), .I2S_BCK(bck), .I2S_LRCK(lrck),
    .I2S_DATA(data)
  );

  i2s_tx #(.DIV(10), .IN_W(IN_W)) dut10 (
    .clk32(clk32), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
    .mute(mute), .sample_ack(ack10), .I2S_BCK(bck10), .I2S_LRCK(lrck10),
    .I2S_DATA(data10)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ack(output int c);
    c = 0;
    do begin
      @(posedge clk32); #1;
      c++;
    end while (!sample_ack && c < 2000);
    if (!sample_ack) check("ack_timeout", 32'(c), 32'd0);
  endtask

  task automatic wait_rises(input int n);
    int cnt = 0;
    int cyc = 0;
    logic prev = bck;
    while (cnt < n && cyc < 5000) begin
      @(posedge clk32); #1;
      cyc++;
      if (bck && !prev) cnt++;
      prev = bck;
    end
    if (cnt < n) check("rise_timeout", 32'(cnt), 32'(n));
  endtask

  task automatic next_frame(input logic [IN_W-1:0] l, input logic [IN_W-1:0] r,
                            input logic m, input logic [31:0] exp);
    int c;
    audio_l = l; audio_r = r; mute = m;
    wait_ack(c);
    sb_q.push_back(exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bck"}, 32'(bck), 32'd0);
    check({tag, "_lrck"}, 32'(lrck), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_ack"}, 32'(sample_ack), 32'd0);
  endtask

  // Frame monitor and ack-period check for the DIV=2 instance
  logic        collecting = 1'b0;
  logic        prev_bck = 1'b0;
  logic        have_ack = 1'b0;
  int          nbits = 0;
  int          ack_gap = 0;
  logic [31:0] got_d, got_l, exp_d;

  always @(negedge clk32) begin
    if (!reset_n) begin
      collecting = 1'b0;
      prev_bck   = 1'b0;
      have_ack   = 1'b0;
    end else begin
      ack_gap++;
      if (collecting && bck && !prev_bck) begin
        got_d = {got_d[30:0], data};
        got_l = {got_l[30:0], lrck};
        nbits++;
        if (nbits == 32) begin
          collecting = 1'b0;
          if (mon_en) begin
            if (sb_q.size() == 0) begin
              check("unexpected_frame", got_d, 32'hxxxx_xxxx);
            end else begin
              exp_d = sb_q.pop_front();
              check("frame_data", got_d, exp_d);
              check("frame_lrck", got_l, LRCK_EXP);
            end
          end
        end
      end
      if (sample_ack) begin
        if (have_ack) check("ack_period_div2", 32'(ack_gap), 32'd128);
        have_ack   = 1'b1;
        ack_gap    = 0;
        collecting = 1'b1;
        nbits      = 0;
      end
      prev_bck = bck;
    end
  end

  // Ack period for the DIV=10 instance
  logic have10 = 1'b0;
  int   gap10 = 0;
  always @(negedge clk32) begin
    if (!reset_n) begin
      have10 = 1'b0;
    end else begin
      gap10++;
      if (ack10) begin
        if (have10) begin
          check("ack_period_div10", 32'(gap10), 32'd640);
          p10_checks++;
        end
        have10 = 1'b1;
        gap10  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_n = 1'b0;
    audio_l = '0; audio_r = '0; mute = 1'b0;
    @(posedge clk32); #1;
    check_reset_outputs("reset_init");
    @(posedge clk32); @(posedge clk32); #1;

    // First frame after release: capture 2*DIV cycles later
    audio_l = 18'h2AAA8; audio_r = 18'h15554;
    reset_n = 1'b1;
    wait_ack(c);
    check("first_ack_latency", 32'(c), 32'd4);
    sb_q.push_back(32'hAAAA_5555);

    next_frame(18'h20000, 18'h1FFFF, 1'b0, 32'h8000_7FFF);
    next_frame(18'h3FFFF, 18'h3FFFF, 1'b1, 32'h0000_0000);
    next_frame(18'h12345, 18'h3C0F0, 1'b0, 32'h48D1_F03C);

    // Change left sample at bit 5 of the frame in flight
    wait_rises(6);
    audio_l = 18'h0ABCD;
    next_frame(18'h0ABCD, 18'h3C0F0, 1'b0, 32'h2AF3_F03C);

    // 3-cycle reset with BCK high at bit_cnt=20; this frame is abandoned
    audio_l = 18'h3FFFF; audio_r = 18'h3FFFF; mute = 1'b0;
    wait_ack(c);
    wait_rises(21);
    check("pre_reset_bck", 32'(bck), 32'd1);
    check("pre_reset_lrck", 32'(lrck), 32'd1);
    check("pre_reset_data", 32'(data), 32'd1);
    reset_n = 1'b0;
    @(posedge clk32); #1;
    check_reset_outputs("reset_midframe");
    @(posedge clk32); @(posedge clk32); #1;
    audio_l = 18'h0F0F0; audio_r = 18'h30303;
    reset_n = 1'b1;
    wait_ack(c);
    check("ack_after_reset3", 32'(c), 32'd4);
    sb_q.push_back(32'h3C3C_C0C0);

    next_frame(18'h15554, 18'h2AAA8, 1'b0, 32'h5555_AAAA);

    // 1-cycle reset pulse at bit_cnt=10; inputs change after release
    audio_l = 18'h2AAA8; audio_r = 18'h2AAA8;
    wait_ack(c);
    wait_rises(11);
    reset_n = 1'b0;
    @(posedge clk32); #1;
    check_reset_outputs("reset_pulse");
    reset_n = 1'b1;
    @(posedge clk32); #1;
    audio_l = 18'h3FFFF; audio_r = 18'h00000;
    wait_ack(c);
    check("ack_after_pulse", 32'(c + 1), 32'd4);
    sb_q.push_back(32'hFFFF_0000);

    next_frame(18'h00000, 18'h20000, 1'b0, 32'h0000_8000);

    c = 0;
    while (sb_q.size() != 0 && c < 2000) begin
      @(posedge clk32); #1;
      c++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;

    repeat (1500) @(posedge clk32);
    #1;
    if (p10_checks == 0) check("div10_period_seen", 32'(p10_checks), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DIV, default 10: clk32 cycles per BCK half-period; legal range 2..255.
REQ-002 Parameter IN_W, default 18: width of the signed audio sample inputs; legal range 16..24.
REQ-003 clk32  input  1  system clock; all logic on its rising edge; single clock domain.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 audio_l  input  IN_W  left sample, signed two's complement, from the C64 core audio mix.
REQ-006 audio_r  input  IN_W  right sample, signed two's complement.
REQ-007 mute  input  1  when high, the frame captured at the next frame start is all zero.
REQ-008 sample_ack  output  1  one-cycle pulse marking the clk32 cycle in which audio_l/audio_r are captured.
REQ-009 I2S_BCK  output  1  bit clock, registered.
REQ-010 I2S_LRCK  output  1  word select, registered; 0 = left, 1 = right.
REQ-011 I2S_DATA  output  1  serial data, registered, MSB first.

Function
REQ-012 Divider div_cnt counts 0..DIV-1; at DIV-1 it wraps to 0 and I2S_BCK toggles; BCK period is exactly 2*DIV clk32 cycles with 50% duty.
REQ-013 Falling BCK event (fe) is the clk32 cycle in which I2S_BCK is toggled from 1 to 0; all LRCK/DATA/bit-counter updates occur only in fe cycles, in the same edge that clears BCK.
REQ-014 5-bit bit_cnt increments on every fe, wrapping 31 -> 0; one frame = 32 BCK periods = 64*DIV clk32 cycles.
REQ-015 On the fe where bit_cnt wraps to 0: capture audio_l[IN_W-1:IN_W-16] into left word and audio_r[IN_W-1:IN_W-16] into right word (truncation, no rounding, no saturation), or zeros if mute=1 in that cycle; sample_ack=1 for that cycle only.
REQ-016 Frame bit n (bit_cnt after the fe): n=0..15 -> left word bit 15-n; n=16..31 -> right word bit 31-n; I2S_DATA shows bit n from that fe until the next fe.
REQ-017 I2S_LRCK after the fe = 1 for n in 15..30, 0 for n = 31 and n in 0..14 (standard I2S: LRCK leads MSB by one BCK).
REQ-018 Captured words are held for the whole frame; changes to audio_l, audio_r or mute between capture fe cycles do not affect the frame in flight.
REQ-019 sample_ack is 0 in every cycle except the capture fe; exactly one pulse per frame.
REQ-020 Receiver samples DATA/LRCK on rising BCK; DATA/LRCK are therefore stable for DIV clk32 cycles around each rising BCK.

Reset
REQ-021 reset_n=0 at a clk32 edge forces, on that edge: div_cnt=0, I2S_BCK=0, bit_cnt=31, I2S_LRCK=0, I2S_DATA=0, sample_ack=0, left/right words=0; applies mid-frame with no completion of the current frame.
REQ-022 After reset_n returns to 1: first BCK rise after DIV cycles, first fe after 2*DIV cycles; that fe has bit_cnt 31->0, so it is a capture fe with sample_ack=1.

Verification
REQ-023 Reset: reset_n=0 for 3 cycles with BCK high and bit_cnt=20 -> next edge BCK=0, LRCK=0, DATA=0, sample_ack=0.
REQ-024 DIV=2, IN_W=18, audio_l=18'h2AAA8, audio_r=18'h15554 -> sample_ack 2*DIV=4 cycles after reset release; 32 DATA bits sampled on BCK rises = 32'hAAAA5555; LRCK 0 for rises 1..15, 1 for rises 16..31, 0 at rise 32.
REQ-025 DIV=10 -> sample_ack period exactly 640 clk32 cycles; audio_l changed at bit 5 of a frame leaves that frame's DATA unchanged, new value appears in the next frame.
REQ-026 audio_l=18'h20000, audio_r=18'h1FFFF -> left word 16'h8000, right word 16'h7FFF on DATA.
REQ-027 mute=1 held across the capture fe with nonzero inputs -> all 32 DATA bits 0; BCK, LRCK and sample_ack continue unchanged.
REQ-028 reset_n pulsed low for 1 cycle at bit_cnt=10 -> outputs take REQ-021 values next edge; new frame starts 4*DIV... precisely: capture fe 2*DIV cycles after release, with data from inputs at that cycle.
